// File: rtl/clct_deadtime_tracker.sv
// clct_deadtime_tracker
//   Sits after the best-1-of-7 half-strip sorter. Each clock it qualifies the
//   sorter winner against hit/pid thresholds and registers an accepted CLCT.
//   It keeps one dead-time counter per key group and feeds bsy back to the
//   sorter, so a group that just fired cannot win again during its dead time.
//
// Ports:
//   clock, global_reset_n     clock, asynchronous active-low reset
//   sync_clear                synchronous clear of counters, outputs, stats
//   trig_en                   1 = accept winners
//   hit_thresh, pid_thresh    minimum nhits / pid of the winner pattern
//   dead_time                 busy clocks per accepted CLCT (0 = no marking)
//   spread_en                 also mark groups g-1 and g+1 busy
//   best_pat/key/bend/qkey/qlt/bsy  sorter winner fields
//   bsy                       per-group busy to sorter, bit g = (cnt[g] != 0)
//   clct_vld, clct_*          accepted CLCT strobe and latched fields
//   grp_err                   strobe: qualified winner carried group index 7
//   nclct                     saturating count of accepted CLCTs
//
// Handshake: clct_vld is a one-clock valid strobe with no ready; the consumer
// must take the clct_* fields in the clock clct_vld is high. The fields hold
// their last accepted values while clct_vld is low.

module clct_deadtime_tracker #(
    parameter int NGRP    = 7,
    parameter int MXPATB  = 7,
    parameter int MXKEYBX = 8,
    parameter int MXBNDB  = 5,
    parameter int MXQLTB  = 6,
    parameter int MXDTB   = 4
) (
    input  logic                 clock,
    input  logic                 global_reset_n,
    input  logic                 sync_clear,
    input  logic                 trig_en,
    input  logic [2:0]           hit_thresh,
    input  logic [3:0]           pid_thresh,
    input  logic [MXDTB-1:0]     dead_time,
    input  logic                 spread_en,
    input  logic [MXPATB-1:0]    best_pat,
    input  logic [MXKEYBX-1:0]   best_key,
    input  logic [MXBNDB-1:0]    best_bend,
    input  logic [MXKEYBX:0]     best_qkey,
    input  logic [MXQLTB-1:0]    best_qlt,
    input  logic                 best_bsy,
    output logic [NGRP-1:0]      bsy,
    output logic                 clct_vld,
    output logic [MXPATB-1:0]    clct_pat,
    output logic [MXKEYBX-1:0]   clct_key,
    output logic [MXBNDB-1:0]    clct_bend,
    output logic [MXKEYBX:0]     clct_qkey,
    output logic [MXQLTB-1:0]    clct_qlt,
    output logic                 grp_err,
    output logic [15:0]          nclct
);

    logic [MXDTB-1:0] cnt [NGRP];
    logic [NGRP-1:0]  load;
    logic [2:0]       grp;
    logic             qualify;
    logic             accept;
    logic             bad_grp;

    // Top three key bits select the key group; value 7 is not a real group.
    assign grp     = best_key[MXKEYBX-1 -: 3];
    assign qualify = trig_en && !best_bsy
                     && (best_pat[MXPATB-1 -: 3] >= hit_thresh)
                     && (best_pat[3:0] >= pid_thresh);
    assign accept  = qualify && (grp != 3'd7);
    assign bad_grp = qualify && (grp == 3'd7);

    // Groups to (re)load this clock. Spread only reaches existing neighbours,
    // so groups 0 and 6 clip instead of wrapping.
    always_comb begin
        for (int i = 0; i < NGRP; i++) begin
            load[i] = 1'b0;
            if (accept && (dead_time != '0)) begin
                if (int'(grp) == i)
                    load[i] = 1'b1;
                else if (spread_en && ((int'(grp) == i + 1) || (int'(grp) + 1 == i)))
                    load[i] = 1'b1;
            end
        end
    end

    always_comb begin
        for (int i = 0; i < NGRP; i++) begin
            bsy[i] = (cnt[i] != '0);
        end
    end

    // Dead-time counters: load beats decrement, so a neighbour that is
    // already counting restarts at dead_time.
    always_ff @(posedge clock or negedge global_reset_n) begin
        if (!global_reset_n) begin
            for (int i = 0; i < NGRP; i++) cnt[i] <= '0;
        end else if (sync_clear) begin
            for (int i = 0; i < NGRP; i++) cnt[i] <= '0;
        end else begin
            for (int i = 0; i < NGRP; i++) begin
                if (load[i])
                    cnt[i] <= dead_time;
                else if (cnt[i] != '0)
                    cnt[i] <= cnt[i] - 1'b1;
            end
        end
    end

    // Registered CLCT output stage and error strobe.
    always_ff @(posedge clock or negedge global_reset_n) begin
        if (!global_reset_n) begin
            clct_vld  <= 1'b0;
            clct_pat  <= '0;
            clct_key  <= '0;
            clct_bend <= '0;
            clct_qkey <= '0;
            clct_qlt  <= '0;
            grp_err   <= 1'b0;
        end else if (sync_clear) begin
            clct_vld  <= 1'b0;
            clct_pat  <= '0;
            clct_key  <= '0;
            clct_bend <= '0;
            clct_qkey <= '0;
            clct_qlt  <= '0;
            grp_err   <= 1'b0;
        end else begin
            clct_vld <= accept;
            grp_err  <= bad_grp;
            if (accept) begin
                clct_pat  <= best_pat;
                clct_key  <= best_key;
                clct_bend <= best_bend;
                clct_qkey <= best_qkey;
                clct_qlt  <= best_qlt;
            end
        end
    end

    // Accepted-CLCT statistics, counted on the output strobe, saturating.
    always_ff @(posedge clock or negedge global_reset_n) begin
        if (!global_reset_n)
            nclct <= '0;
        else if (sync_clear)
            nclct <= '0;
        else if (clct_vld && (nclct != 16'hFFFF))
            nclct <= nclct + 16'd1;
    end

endmodule

// File: tb/tb_clct_deadtime_tracker.sv
module tb_clct_deadtime_tracker;

  logic        clock;
  logic        global_reset_n;
  logic        sync_clear;
  logic        trig_en;
  logic [2:0]  hit_thresh;
  logic [3:0]  pid_thresh;
  logic [3:0]  dead_time;
  logic        spread_en;
  logic [6:0]  best_pat;
  logic [7:0]  best_key;
  logic [4:0]  best_bend;
  logic [8:0]  best_qkey;
  logic [5:0]  best_qlt;
  logic        best_bsy;
  logic [6:0]  bsy;
  logic        clct_vld;
  logic [6:0]  clct_pat;
  logic [7:0]  clct_key;
  logic [4:0]  clct_bend;
  logic [8:0]  clct_qkey;
  logic [5:0]  clct_qlt;
  logic        grp_err;
  logic [15:0] nclct;

  // Sorter model: the winner's group reports busy when the tracker marks it.
  logic        use_model;
  logic        manual_bsy;
  logic [7:0]  bsy_ext;
  assign bsy_ext  = {1'b0, bsy};
  assign best_bsy = manual_bsy | (use_model & bsy_ext[best_key[7:5]]);

  int n_cmp = 0;
  int n_mis = 0;

  clct_deadtime_tracker dut (
    .clock(clock), .global_reset_n(global_reset_n), .sync_clear(sync_clear),
    .trig_en(trig_en), .hit_thresh(hit_thresh), .pid_thresh(pid_thresh),
    .dead_time(dead_time), .spread_en(spread_en),
    .best_pat(best_pat), .best_key(best_key), .best_bend(best_bend),
    .best_qkey(best_qkey), .best_qlt(best_qlt), .best_bsy(best_bsy),
    .bsy(bsy), .clct_vld(clct_vld), .clct_pat(clct_pat), .clct_key(clct_key),
    .clct_bend(clct_bend), .clct_qkey(clct_qkey), .clct_qlt(clct_qlt),
    .grp_err(grp_err), .nclct(nclct)
  );

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Advance one active edge and settle away from it.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic pulse_accept(input logic [7:0] key);
    best_key = key;
    trig_en  = 1'b1;
    step();
    trig_en  = 1'b0;
  endtask

  initial begin
    global_reset_n = 1'b0;
    sync_clear = 1'b0; trig_en = 1'b0;
    hit_thresh = 3'd3; pid_thresh = 4'd2; dead_time = 4'd4; spread_en = 1'b0;
    best_pat = 7'h6A; best_key = 8'h45; best_bend = 5'h15; best_qkey = 9'h123;
    best_qlt = 6'h2C; use_model = 1'b1; manual_bsy = 1'b0;
    #2;
    check_eq("rst_bsy", 32'(bsy), 32'h0);
    check_eq("rst_vld", 32'(clct_vld), 32'h0);
    check_eq("rst_key", 32'(clct_key), 32'h0);
    check_eq("rst_grp_err", 32'(grp_err), 32'h0);
    check_eq("rst_nclct", 32'(nclct), 32'h0);
    step(); step();
    global_reset_n = 1'b1;
    step();

    // 1: basic accept, dead time 4, sorter re-wins after the dead time
    trig_en = 1'b1;
    step();
    check_eq("t1_vld", 32'(clct_vld), 32'h1);
    check_eq("t1_key", 32'(clct_key), 32'h45);
    check_eq("t1_pat", 32'(clct_pat), 32'h6A);
    check_eq("t1_qkey", 32'(clct_qkey), 32'h123);
    check_eq("t1_bsy1", 32'(bsy), 32'h04);
    for (int i = 2; i <= 4; i++) begin
      step();
      check_eq("t1_bsy_hold", 32'(bsy), 32'h04);
      check_eq("t1_vld_low", 32'(clct_vld), 32'h0);
    end
    step();
    check_eq("t1_bsy_free", 32'(bsy), 32'h0);
    check_eq("t1_vld_n5", 32'(clct_vld), 32'h0);
    step();
    check_eq("t1_rewin_vld", 32'(clct_vld), 32'h1);
    trig_en = 1'b0;
    repeat (5) step();
    check_eq("t1_nclct", 32'(nclct), 32'd2);
    check_eq("t1_bsy_drain", 32'(bsy), 32'h0);

    // 2: spread at the edges, no wrap
    spread_en = 1'b1; dead_time = 4'd3;
    pulse_accept(8'h03);
    check_eq("t2_g0_vld", 32'(clct_vld), 32'h1);
    check_eq("t2_g0_bsy", 32'(bsy), 32'h03);
    step(); check_eq("t2_g0_bsy2", 32'(bsy), 32'h03);
    step(); check_eq("t2_g0_bsy3", 32'(bsy), 32'h03);
    step(); check_eq("t2_g0_free", 32'(bsy), 32'h00);
    pulse_accept(8'hC7);
    check_eq("t2_g6_key", 32'(clct_key), 32'hC7);
    check_eq("t2_g6_bsy", 32'(bsy), 32'h60);
    step(); check_eq("t2_g6_bsy2", 32'(bsy), 32'h60);
    step(); check_eq("t2_g6_bsy3", 32'(bsy), 32'h60);
    step(); check_eq("t2_g6_free", 32'(bsy), 32'h00);

    // 3: rejects, group 7, threshold boundaries, dead_time 0
    spread_en = 1'b0; dead_time = 4'd4;
    best_pat = 7'h2A; best_key = 8'h45; trig_en = 1'b1;
    step();
    check_eq("t3_lowhits_vld", 32'(clct_vld), 32'h0);
    check_eq("t3_lowhits_bsy", 32'(bsy), 32'h0);
    best_pat = 7'h6A; manual_bsy = 1'b1;
    step();
    check_eq("t3_bestbsy_vld", 32'(clct_vld), 32'h0);
    manual_bsy = 1'b0; trig_en = 1'b0;
    step();
    check_eq("t3_trigoff_vld", 32'(clct_vld), 32'h0);
    check_eq("t3_trigoff_err", 32'(grp_err), 32'h0);
    best_key = 8'hE5; trig_en = 1'b1;
    step();
    check_eq("t3_g7_err", 32'(grp_err), 32'h1);
    check_eq("t3_g7_vld", 32'(clct_vld), 32'h0);
    check_eq("t3_g7_bsy", 32'(bsy), 32'h0);
    check_eq("t3_g7_key_held", 32'(clct_key), 32'hC7);
    trig_en = 1'b0;
    step();
    check_eq("t3_g7_err_clr", 32'(grp_err), 32'h0);
    pid_thresh = 4'd10;
    pulse_accept(8'h45);
    check_eq("t3_pid_eq_vld", 32'(clct_vld), 32'h1);
    check_eq("t3_pid_eq_bsy", 32'(bsy), 32'h04);
    repeat (4) step();
    pid_thresh = 4'd11;
    pulse_accept(8'h45);
    check_eq("t3_pid_low_vld", 32'(clct_vld), 32'h0);
    pid_thresh = 4'd2; dead_time = 4'd0;
    pulse_accept(8'h45);
    check_eq("t3_dt0_vld", 32'(clct_vld), 32'h1);
    check_eq("t3_dt0_bsy", 32'(bsy), 32'h0);

    // 4: neighbour already counting is reloaded, not max'ed
    dead_time = 4'd3;
    pulse_accept(8'h65);
    check_eq("t4_g3_bsy", 32'(bsy), 32'h08);
    step(); step();
    spread_en = 1'b1; dead_time = 4'd5;
    pulse_accept(8'h85);
    check_eq("t4_reload_vld", 32'(clct_vld), 32'h1);
    check_eq("t4_reload_bsy", 32'(bsy), 32'h38);
    for (int i = 2; i <= 5; i++) begin
      step();
      check_eq("t4_reload_hold", 32'(bsy), 32'h38);
    end
    step();
    check_eq("t4_reload_free", 32'(bsy), 32'h00);

    // 5: async reset mid dead time, sync_clear beats an accept
    spread_en = 1'b0; dead_time = 4'd4;
    pulse_accept(8'h45);
    check_eq("t5_pre_vld", 32'(clct_vld), 32'h1);
    #2;
    global_reset_n = 1'b0;
    #1;
    check_eq("t5_arst_bsy", 32'(bsy), 32'h0);
    check_eq("t5_arst_vld", 32'(clct_vld), 32'h0);
    check_eq("t5_arst_key", 32'(clct_key), 32'h0);
    check_eq("t5_arst_nclct", 32'(nclct), 32'h0);
    #1;
    global_reset_n = 1'b1;
    step();
    check_eq("t5_post_bsy", 32'(bsy), 32'h0);
    pulse_accept(8'h45);
    check_eq("t5_acc_vld", 32'(clct_vld), 32'h1);
    best_key = 8'hA5; trig_en = 1'b1; sync_clear = 1'b1;
    step();
    check_eq("t5_sclr_vld", 32'(clct_vld), 32'h0);
    check_eq("t5_sclr_bsy", 32'(bsy), 32'h0);
    check_eq("t5_sclr_key", 32'(clct_key), 32'h0);
    check_eq("t5_sclr_nclct", 32'(nclct), 32'h0);
    sync_clear = 1'b0; trig_en = 1'b0;
    step();

    // 6: nclct saturation over 65,540 back-to-back accepts
    dead_time = 4'd0; best_key = 8'h45; trig_en = 1'b1;
    repeat (1000) step();
    check_eq("t6_nclct_1000", 32'(nclct), 32'd999);
    repeat (64540) step();
    check_eq("t6_nclct_sat", 32'(nclct), 32'hFFFF);
    repeat (3) step();
    check_eq("t6_nclct_hold", 32'(nclct), 32'hFFFF);
    trig_en = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
